ysyx_22041412_icache: RTL and testbench
=======================================

YSYX_22041412_ICACHE -- requirements
Module: ysyx_22041412_icache

Interface
REQ-001 SHALL have parameter IDX_W, default 4, index bits (2**IDX_W lines of 128 bit).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port valid_i  input  1  IFU fetch request.
REQ-005 SHALL have port addr_i  input  32  IFU fetch address (bits [3:0] ignored).
REQ-006 SHALL have port clean_i  input  1  IFU abandon-request.
REQ-007 SHALL have port fence_i  input  1  invalidate all lines.
REQ-008 SHALL have port ready_o  output  1  one-cycle pulse, data_o valid.
REQ-009 SHALL have port data_o  output  128  fetched line.
REQ-010 SHALL have port clean_ack_o  output  1  high while the cache is in IDLE.
REQ-011 SHALL have port mem_valid_o  output  1  refill read request.
REQ-012 SHALL have port mem_addr_o  output  32  refill address, 16-byte aligned.
REQ-013 SHALL have port mem_ready_i  input  1  beat accepted/returned.
REQ-014 SHALL have port mem_rdata_i  input  64  refill beat data.
REQ-015 SHALL have port hit_cnt_o  output  32  hit counter.
REQ-016 SHALL have port miss_cnt_o  output  32  miss counter.

Function
REQ-017 SHALL be direct-mapped: index = addr[IDX_W+3:4], tag = addr[31:IDX_W+4], one valid bit per line.
REQ-018 SHALL implement states IDLE, LOOKUP, REFILL, RESP.
REQ-019 SHALL accept a request in IDLE when valid_i=1 and clean_i=0 and fence_i=0, latching addr_i and moving to LOOKUP.
REQ-020 SHALL stay in IDLE when clean_i or fence_i is high (clean/fence priority over valid_i).
REQ-021 SHALL, in LOOKUP on hit (valid & tag match), move to RESP and increment hit_cnt_o.
REQ-022 SHALL, in LOOKUP on miss, move to REFILL, assert mem_valid_o next cycle, and increment miss_cnt_o.
REQ-023 SHALL, in LOOKUP with clean_i=1, return to IDLE without response and without counting.
REQ-024 SHALL hold mem_valid_o=1 and mem_addr_o={addr[31:4],4'b0} constant throughout REFILL.
REQ-025 SHALL treat each cycle with mem_valid_o & mem_ready_i as one beat: beat 0 = bits [63:0], beat 1 = bits [127:64].
REQ-026 SHALL, after beat 1, deassert mem_valid_o, write data and tag, set valid, then go to RESP.
REQ-027 SHALL never abort a burst: clean_i seen during REFILL is latched; the refill completes and is written, RESP is skipped, and the state returns to IDLE.
REQ-028 SHALL, in RESP, drive ready_o=1 and data_o=line for exactly one cycle, then return to IDLE; clean_i in RESP suppresses ready_o.
REQ-029 SHALL give hit latency: accept at T, ready_o at T+2; miss: ready_o one cycle after the cycle of beat 1.
REQ-030 SHALL keep ready_o=0 in all states other than RESP; data_o is don't-care when ready_o=0.
REQ-031 SHALL, on fence_i in IDLE, clear all valid bits in one cycle; fence_i in other states is latched and applied on return to IDLE.
REQ-032 SHALL wrap counters at 2**32-1 to 0.
REQ-033 SHALL, when a refill targets a line whose valid bit is set, replace that line.

Reset
REQ-034 SHALL, while rst=0 at a clock edge, enter IDLE, clear all valid bits, clear counters, ready_o=0, mem_valid_o=0, clean_ack_o=1, and drop latched clean/fence.
REQ-035 SHALL obey reset mid-REFILL immediately: mem_valid_o=0 next cycle, line not written.

Verification
REQ-036 SHALL be tested with cold miss: addr_i=0x80000000 with mem beats 0x1111/0x2222 -> mem_addr_o=0x80000000, then ready_o with data_o[63:0]=0x1111, data_o[127:64]=0x2222, miss_cnt_o=1.
REQ-037 SHALL be tested with hit: re-request 0x80000004 after the above -> ready_o at T+2, same data, no mem_valid_o, hit_cnt_o=1.
REQ-038 SHALL be tested with conflict: 0x80000100 (same index, IDX_W=4) -> refill, then 0x80000000 misses again, miss_cnt_o=3.
REQ-039 SHALL be tested with clean during REFILL: clean_i pulsed after beat 0 -> beat 1 accepted, no ready_o, clean_ack_o=1 the cycle after beat 1, line valid on a later hit.
REQ-040 SHALL be tested with fence_i in IDLE: then 0x80000000 -> miss, mem_valid_o asserted.
REQ-041 SHALL be tested with reset mid-REFILL: rst=0 after beat 0 -> mem_valid_o=0, counters 0, next request misses.

Source files
------------

// File: rtl/ysyx_22041412_icache.sv
// ysyx_22041412_icache
// Direct-mapped instruction cache with 128-bit lines and a two-beat, 64-bit
// refill port. Each line has one valid bit. The cache keeps hit and miss
// counters and supports an abandon request (clean_i) and a full invalidate
// (fence_i).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a fetch; applies fence_i; clean_ack_o is high
// LOOKUP | latched address compared against tag/valid
// REFILL | two-beat memory read of the missing line
// RESP   | one-cycle ready_o pulse with the line on data_o
//
// Ports
//   clk, rst            : clock and synchronous active-low reset
//   valid_i, addr_i     : fetch request from the IFU (addr_i[3:0] ignored)
//   clean_i             : IFU abandons its request
//   fence_i             : invalidate every line
//   ready_o, data_o     : response pulse and fetched line
//   clean_ack_o         : high while the cache is in IDLE
//   mem_valid_o/addr_o  : refill read request, 16-byte aligned
//   mem_ready_i/rdata_i : refill beat handshake and data
//   hit_cnt_o/miss_cnt_o: free-running, wrapping event counters
module ysyx_22041412_icache #(
  parameter int IDX_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [31:0]  addr_i,
  input  logic         clean_i,
  input  logic         fence_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  output logic         clean_ack_o,
  output logic         mem_valid_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_ready_i,
  input  logic [63:0]  mem_rdata_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [31:4]      addr_q;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [127:0]     data_arr [LINES];

  logic [63:0] beat0_q;
  logic        beat_q;
  logic        clean_pend;
  logic        fence_pend;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  logic hit;
  logic beat_fire;
  logic last_beat;
  logic accept;
  logic hit_inc;
  logic miss_inc;
  logic fence_apply;
  logic unused_addr_bits;

  assign idx = addr_q[IDX_W+3:4];
  assign tag = addr_q[31:IDX_W+4];
  assign hit = valid_q[idx] && (tag_arr[idx] == tag);

  assign beat_fire = (state == REFILL) && mem_ready_i;
  assign last_beat = beat_fire && beat_q;

  assign unused_addr_bits = ^addr_i[3:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    fence_apply = 1'b0;
    ready_o     = 1'b0;
    case (state)
      IDLE: begin
        if (fence_i) begin
          fence_apply = 1'b1;
        end else if (!clean_i && valid_i) begin
          accept  = 1'b1;
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        if (clean_i) begin
          state_n = IDLE;
        end else if (hit) begin
          hit_inc = 1'b1;
          state_n = RESP;
        end else begin
          miss_inc = 1'b1;
          state_n  = REFILL;
        end
      end
      REFILL: begin
        // The burst always completes; an abandon seen during it only
        // skips the response.
        if (last_beat) state_n = (clean_pend || clean_i) ? IDLE : RESP;
      end
      RESP: begin
        ready_o = !clean_i;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A fence that arrived while busy takes effect as we re-enter IDLE,
    // so the next request already sees the invalidated array.
    if ((state != IDLE) && (state_n == IDLE) && (fence_pend || fence_i))
      fence_apply = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      beat_q     <= 1'b0;
      clean_pend <= 1'b0;
      fence_pend <= 1'b0;
    end else begin
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;

      if (miss_inc)       beat_q <= 1'b0;
      else if (beat_fire) beat_q <= ~beat_q;

      if (last_beat)                       clean_pend <= 1'b0;
      else if ((state == REFILL) && clean_i) clean_pend <= 1'b1;

      if (fence_apply)                     fence_pend <= 1'b0;
      else if ((state != IDLE) && fence_i) fence_pend <= 1'b1;

      // Invalidate wins over a refill completing in the same cycle.
      if (fence_apply)    valid_q      <= '0;
      else if (last_beat) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q <= addr_i[31:4];
    if (beat_fire && !beat_q) beat0_q <= mem_rdata_i;
    // Gated by rst so a reset landing on the final beat leaves the line alone.
    if (rst && last_beat) begin
      data_arr[idx] <= {mem_rdata_i, beat0_q};
      tag_arr[idx]  <= tag;
    end
  end

  assign data_o      = data_arr[idx];
  assign clean_ack_o = (state == IDLE);
  assign mem_valid_o = (state == REFILL);
  assign mem_addr_o  = {addr_q, 4'b0000};
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_22041412_icache.sv
module tb_ysyx_22041412_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         clean_i = 1'b0;
  logic         fence_i = 1'b0;
  logic         mem_ready_i = 1'b0;
  logic [63:0]  mem_rdata_i = '0;
  logic         ready_o;
  logic [127:0] data_o;
  logic         clean_ack_o;
  logic         mem_valid_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  ysyx_22041412_icache #(.IDX_W(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .addr_i(addr_i),
    .clean_i(clean_i), .fence_i(fence_i), .ready_o(ready_o), .data_o(data_o),
    .clean_ack_o(clean_ack_o), .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  logic [127:0] sb[$];
  bit           m_valid[16];
  logic [23:0]  m_tag[16];
  logic [31:0]  exp_hit = '0;
  logic [31:0]  exp_miss = '0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:4], 4'b0000};
    if (la == 32'h8000_0000) return {64'h2222, 64'h1111};
    return {32'h5A5A_0000 ^ la, ~la, 32'hA5A5_0000 ^ la, la};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input bit stall);
    bit exp_h, got;
    int ix, beats, rdy_c, b1_c;
    logic [127:0] ln, exp_d;
    ix = int'(a[7:4]);
    exp_h = m_valid[ix] && (m_tag[ix] == a[31:8]);
    ln = mem_line(a);
    sb.push_back(ln);
    got = 0; beats = 0; rdy_c = 0; b1_c = -10;
    cyc(); valid_i = 1; addr_i = a; #1;
    vec++;
    if (clean_ack_o !== 1'b1) begin
      err++; $display("FAIL req_idle addr=%h clean_ack_o=%b expected 1", a, clean_ack_o);
    end
    for (int c = 1; c <= 60; c++) begin
      cyc(); valid_i = 0; addr_i = $urandom; mem_ready_i = 0; #1;
      if (mem_valid_o) begin
        vec++;
        if (mem_addr_o !== {a[31:4], 4'b0000}) begin
          err++; $display("FAIL mem_addr got %h expected %h", mem_addr_o, {a[31:4], 4'b0000});
        end
        mem_ready_i = !stall || ($urandom_range(0, 2) == 0);
        if (mem_ready_i) begin
          mem_rdata_i = (beats == 0) ? ln[63:0] : ln[127:64];
          if (beats == 1) b1_c = c;
          beats++;
        end
      end
      if (ready_o) begin
        got = 1; rdy_c = c;
        break;
      end
    end
    mem_ready_i = 0;
    vec++;
    if (got !== 1'b1) begin
      err++; $display("FAIL req_timeout addr=%h no ready_o within 60 cycles", a);
      if (sb.size() > 0) void'(sb.pop_back());
    end else begin
      exp_d = sb.pop_front();
      vec++;
      if (data_o !== exp_d) begin
        err++; $display("FAIL req_data addr=%h got %h expected %h", a, data_o, exp_d);
      end
      vec++;
      if (exp_h) begin
        if (rdy_c !== 2 || beats !== 0) begin
          err++; $display("FAIL hit_latency addr=%h ready at %0d beats %0d expected 2/0", a, rdy_c, beats);
        end
      end else begin
        if (beats !== 2 || rdy_c !== b1_c + 1) begin
          err++; $display("FAIL miss_latency addr=%h ready at %0d beats %0d expected %0d/2", a, rdy_c, beats, b1_c + 1);
        end
      end
    end
    if (exp_h) exp_hit++;
    else begin
      exp_miss++; m_valid[ix] = 1'b1; m_tag[ix] = a[31:8];
    end
    vec++;
    if (hit_cnt_o !== exp_hit || miss_cnt_o !== exp_miss) begin
      err++; $display("FAIL req_counters addr=%h got hit %0d miss %0d expected %0d/%0d",
                      a, hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
    end
  endtask

  task automatic test_reset();
    rst = 0; valid_i = 1; addr_i = 32'h8000_0000;
    cyc(); cyc(); cyc();
    valid_i = 0; #1;
    vec++;
    if (ready_o !== 1'b0 || mem_valid_o !== 1'b0 || clean_ack_o !== 1'b1) begin
      err++; $display("FAIL reset_ctrl ready=%b mem_valid=%b clean_ack=%b expected 0/0/1",
                      ready_o, mem_valid_o, clean_ack_o);
    end
    vec++;
    if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      err++; $display("FAIL reset_counters hit %0d miss %0d expected 0/0", hit_cnt_o, miss_cnt_o);
    end
    model_clear(); exp_hit = 0; exp_miss = 0;
    rst = 1;
  endtask

  task automatic test_cold_miss();
    req(32'h8000_0000, 0);
    vec++;
    if (miss_cnt_o !== 32'd1) begin
      err++; $display("FAIL cold_miss_cnt got %0d expected 1", miss_cnt_o);
    end
  endtask

  task automatic test_hit();
    req(32'h8000_0004, 0);
    vec++;
    if (hit_cnt_o !== 32'd1) begin
      err++; $display("FAIL hit_cnt got %0d expected 1", hit_cnt_o);
    end
  endtask

  task automatic test_conflict();
    req(32'h8000_0100, 1);
    req(32'h8000_0000, 0);
    vec++;
    if (miss_cnt_o !== 32'd3) begin
      err++; $display("FAIL conflict_miss_cnt got %0d expected 3", miss_cnt_o);
    end
  endtask

  task automatic test_clean_refill();
    logic [31:0] a;
    logic [127:0] ln;
    a = 32'h8000_0200; ln = mem_line(a);
    cyc(); valid_i = 1; addr_i = a; #1;
    cyc(); valid_i = 0; #1;
    cyc(); #1;
    vec++;
    if (mem_valid_o !== 1'b1) begin
      err++; $display("FAIL clean_refill_req mem_valid=%b expected 1", mem_valid_o);
    end
    mem_ready_i = 1; mem_rdata_i = ln[63:0];
    cyc(); mem_ready_i = 0; clean_i = 1; #1;
    vec++;
    if (mem_valid_o !== 1'b1 || ready_o !== 1'b0) begin
      err++; $display("FAIL clean_refill_hold mem_valid=%b ready=%b expected 1/0", mem_valid_o, ready_o);
    end
    cyc(); clean_i = 0; #1;
    vec++;
    if (mem_valid_o !== 1'b1) begin
      err++; $display("FAIL clean_refill_beat1 mem_valid=%b expected 1", mem_valid_o);
    end
    mem_ready_i = 1; mem_rdata_i = ln[127:64];
    cyc(); mem_ready_i = 0; #1;
    vec++;
    if (clean_ack_o !== 1'b1 || ready_o !== 1'b0 || mem_valid_o !== 1'b0) begin
      err++; $display("FAIL clean_refill_done clean_ack=%b ready=%b mem_valid=%b expected 1/0/0",
                      clean_ack_o, ready_o, mem_valid_o);
    end
    cyc(); #1;
    vec++;
    if (ready_o !== 1'b0) begin
      err++; $display("FAIL clean_refill_noresp ready=%b expected 0", ready_o);
    end
    exp_miss++; m_valid[0] = 1'b1; m_tag[0] = a[31:8];
    req(32'h8000_0208, 0);
  endtask

  task automatic test_clean_lookup();
    cyc(); valid_i = 1; addr_i = 32'h8000_0208; #1;
    cyc(); valid_i = 0; clean_i = 1; #1;
    cyc(); clean_i = 0; #1;
    vec++;
    if (clean_ack_o !== 1'b1 || ready_o !== 1'b0) begin
      err++; $display("FAIL clean_lookup clean_ack=%b ready=%b expected 1/0", clean_ack_o, ready_o);
    end
    cyc(); #1;
    vec++;
    if (ready_o !== 1'b0 || hit_cnt_o !== exp_hit || miss_cnt_o !== exp_miss) begin
      err++; $display("FAIL clean_lookup_cnt ready=%b hit %0d miss %0d expected 0/%0d/%0d",
                      ready_o, hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
    end
  endtask

  task automatic test_clean_resp();
    cyc(); valid_i = 1; addr_i = 32'h8000_0208; #1;
    cyc(); valid_i = 0; #1;
    cyc(); clean_i = 1; #1;
    exp_hit++;
    vec++;
    if (ready_o !== 1'b0 || clean_ack_o !== 1'b0 || hit_cnt_o !== exp_hit) begin
      err++; $display("FAIL clean_resp ready=%b clean_ack=%b hit %0d expected 0/0/%0d",
                      ready_o, clean_ack_o, hit_cnt_o, exp_hit);
    end
    cyc(); clean_i = 0; #1;
    vec++;
    if (clean_ack_o !== 1'b1 || ready_o !== 1'b0) begin
      err++; $display("FAIL clean_resp_idle clean_ack=%b ready=%b expected 1/0", clean_ack_o, ready_o);
    end
  endtask

  task automatic test_fence();
    cyc(); fence_i = 1; valid_i = 1; addr_i = 32'h8000_0000; #1;
    cyc(); fence_i = 0; valid_i = 0; #1;
    vec++;
    if (clean_ack_o !== 1'b1 || mem_valid_o !== 1'b0) begin
      err++; $display("FAIL fence_priority clean_ack=%b mem_valid=%b expected 1/0", clean_ack_o, mem_valid_o);
    end
    model_clear();
    req(32'h8000_0000, 0);
  endtask

  task automatic test_fence_pending();
    logic [127:0] exp_d;
    sb.push_back(mem_line(32'h8000_0000));
    cyc(); valid_i = 1; addr_i = 32'h8000_0000; #1;
    cyc(); valid_i = 0; fence_i = 1; #1;
    cyc(); fence_i = 0; #1;
    exp_d = sb.pop_front();
    vec++;
    if (ready_o !== 1'b1 || data_o !== exp_d) begin
      err++; $display("FAIL fence_pend_resp ready=%b data=%h expected 1/%h", ready_o, data_o, exp_d);
    end
    exp_hit++;
    model_clear();
    req(32'h8000_0000, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      a = 32'h8000_0000 + ($urandom_range(0, 2) << 12) + ($urandom_range(0, 3) << 4)
          + $urandom_range(0, 15);
      req(a, (i % 2) == 1);
    end
  endtask

  task automatic test_reset_refill();
    logic [31:0] a;
    logic [127:0] ln;
    a = 32'h8000_03F0; ln = mem_line(a);
    cyc(); valid_i = 1; addr_i = a; #1;
    cyc(); valid_i = 0; #1;
    cyc(); #1;
    vec++;
    if (mem_valid_o !== 1'b1) begin
      err++; $display("FAIL rst_refill_req mem_valid=%b expected 1", mem_valid_o);
    end
    mem_ready_i = 1; mem_rdata_i = ln[63:0];
    cyc(); rst = 0; mem_rdata_i = ln[127:64]; #1;
    cyc(); rst = 1; mem_ready_i = 0; #1;
    vec++;
    if (mem_valid_o !== 1'b0 || clean_ack_o !== 1'b1 || ready_o !== 1'b0) begin
      err++; $display("FAIL rst_refill_ctrl mem_valid=%b clean_ack=%b ready=%b expected 0/1/0",
                      mem_valid_o, clean_ack_o, ready_o);
    end
    vec++;
    if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      err++; $display("FAIL rst_refill_cnt hit %0d miss %0d expected 0/0", hit_cnt_o, miss_cnt_o);
    end
    model_clear(); exp_hit = 0; exp_miss = 0;
    req(a, 0);
    req(a, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_clean_refill();
    test_clean_lookup();
    test_clean_resp();
    test_fence();
    test_fence_pending();
    test_back_to_back();
    test_reset_refill();
    vec++;
    if (sb.size() !== 0) begin
      err++; $display("FAIL scoreboard_leftover %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
